// File: rtl/rr_mux_arbiter.sv
// Registered two-source round-robin arbiter feeding a single-entry output stage.
// Optional per-source saturating transfer counters are enabled by defining RR_MUX_CNT_EN.
module rr_mux_arbiter #(
    parameter int unsigned size = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [size-1:0] A,
    input  logic            A_VALID,
    output logic            A_READY,
    input  logic [size-1:0] B,
    input  logic            B_VALID,
    output logic            B_READY,
    output logic [size-1:0] OUT,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic            SEL
`ifdef RR_MUX_CNT_EN
    ,
    output logic [7:0]      CNT_A,
    output logic [7:0]      CNT_B
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last;
    logic   grant_a;
    logic   grant_b;
    logic   load_ok;
    logic   xfer;

    // LAST = 1 means B was served most recently, so A wins the next tie
    always_comb begin
        grant_a = A_VALID && (!B_VALID || last);
        grant_b = B_VALID && (!A_VALID || !last);
        load_ok = (state == EMPTY) || OUT_READY;
        A_READY = !RST && load_ok && grant_a;
        B_READY = !RST && load_ok && grant_b;
        xfer    = A_READY || B_READY;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (xfer) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (xfer) begin
                    state_nxt = FULL;
                end else if (OUT_READY) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        OUT_VALID = (state == FULL);
    end

    // Data, origin and round-robin pointer only move on an accepted word
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT  <= '0;
            SEL  <= 1'b0;
            last <= 1'b1;
        end else if (xfer) begin
            OUT  <= A_READY ? A : B;
            SEL  <= B_READY;
            last <= B_READY;
        end
    end

`ifdef RR_MUX_CNT_EN
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge CLK) begin
        if (RST) begin
            CNT_A <= '0;
            CNT_B <= '0;
        end else begin
            if (A_READY && (CNT_A != CNT_MAX)) begin
                CNT_A <= CNT_A + CNT_W'(1);
            end
            if (B_READY && (CNT_B != CNT_MAX)) begin
                CNT_B <= CNT_B + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a queue-based reference model of the arbiter
// plus a monitor that checks a 4-bit and a 6-bit instance every cycle.
module tb_rr_mux_arbiter;

    localparam int unsigned W  = 4;
    localparam int unsigned W6 = 6;
    localparam logic [W6-1:0] PAT_A = 6'b011001;
    localparam logic [W6-1:0] PAT_B = 6'b101110;

    logic          CLK = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  a_d = '0;
    logic [W-1:0]  b_d = '0;
    logic          a_v = 1'b0;
    logic          b_v = 1'b0;
    logic          o_r = 1'b1;

    logic          a_rdy, b_rdy, o_v, sel;
    logic [W-1:0]  o_d;
    logic [W6-1:0] a6, b6, o6;
    logic          a_rdy6, b_rdy6, o_v6, sel6;
`ifdef RR_MUX_CNT_EN
    logic [7:0]    cnt_a, cnt_b, cnt_a6, cnt_b6;
`endif

    assign a6 = PAT_A ^ W6'(a_d);
    assign b6 = PAT_B ^ W6'(b_d);

    rr_mux_arbiter #(.size(W)) dut (
        .CLK(CLK), .RST(rst),
        .A(a_d), .A_VALID(a_v), .A_READY(a_rdy),
        .B(b_d), .B_VALID(b_v), .B_READY(b_rdy),
        .OUT(o_d), .OUT_VALID(o_v), .OUT_READY(o_r), .SEL(sel)
`ifdef RR_MUX_CNT_EN
        , .CNT_A(cnt_a), .CNT_B(cnt_b)
`endif
    );

    rr_mux_arbiter #(.size(W6)) dut6 (
        .CLK(CLK), .RST(rst),
        .A(a6), .A_VALID(a_v), .A_READY(a_rdy6),
        .B(b6), .B_VALID(b_v), .B_READY(b_rdy6),
        .OUT(o6), .OUT_VALID(o_v6), .OUT_READY(o_r), .SEL(sel6)
`ifdef RR_MUX_CNT_EN
        , .CNT_A(cnt_a6), .CNT_B(cnt_b6)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of words the sink is owed, plus who was served last
    logic [W:0] q[$];          // {source, data}
    bit         m_valid = 1'b0;
    int         m_last  = 1;   // source served most recently (0 = A, 1 = B)
    int         m_ca    = 0;
    int         m_cb    = 0;

    function automatic int winner(input logic av, input logic bv, input int last_src);
        if (av && bv) return 1 - last_src;
        if (av)       return 0;
        if (bv)       return 1;
        return -1;
    endfunction

    function automatic logic [W6-1:0] map6(input logic [W:0] e);
        return (e[W] ? PAT_B : PAT_A) ^ W6'(e[W-1:0]);
    endfunction

    always @(posedge CLK) begin
        int w;
        if (rst) begin
            q.delete();
            m_valid = 1'b0;
            m_last  = 1;
            m_ca    = 0;
            m_cb    = 0;
        end else begin
            w = winner(a_v, b_v, m_last);
            if ((!m_valid || o_r) && w >= 0) begin
                q.push_back({w[0], (w == 0) ? a_d : b_d});
                m_last  = w;
                m_valid = 1'b1;
                if (w == 0 && m_ca < 255) m_ca++;
                if (w == 1 && m_cb < 255) m_cb++;
            end else if (m_valid && o_r) begin
                m_valid = 1'b0;
            end
        end
    end

    // Monitor: compares every cycle away from the active edge
    logic [W:0]    hold  = '0;
    logic [W6-1:0] hold6 = '0;

    initial begin
        forever begin
            logic [W:0] e;
            int  w;
            bit  ld;
            @(negedge CLK);
            #2;
            w  = winner(a_v, b_v, m_last);
            ld = !rst && (!m_valid || o_r);
            chk("a_ready", 32'(a_rdy), 32'(ld && w == 0));
            chk("b_ready", 32'(b_rdy), 32'(ld && w == 1));
            chk("a_ready_w6", 32'(a_rdy6), 32'(ld && w == 0));
            chk("b_ready_w6", 32'(b_rdy6), 32'(ld && w == 1));
            chk("out_valid", 32'(o_v), 32'(m_valid));
            chk("out_valid_w6", 32'(o_v6), 32'(m_valid));
            if (o_v) begin
                if (q.size() == 0) begin
                    chk("queue_has_word", 32'(0), 32'(1));
                end else begin
                    e = q[0];
                    chk("out_data", 32'(o_d), 32'(e[W-1:0]));
                    chk("out_sel", 32'(sel), 32'(e[W]));
                    chk("out_data_w6", 32'(o6), 32'(map6(e)));
                    chk("out_sel_w6", 32'(sel6), 32'(e[W]));
                    if (!rst && o_r) begin
                        q.delete(0);
                        hold  = e;
                        hold6 = map6(e);
                    end
                end
            end else begin
                chk("hold_data", 32'(o_d), 32'(hold[W-1:0]));
                chk("hold_sel", 32'(sel), 32'(hold[W]));
                chk("hold_data_w6", 32'(o6), 32'(hold6));
            end
`ifdef RR_MUX_CNT_EN
            chk("cnt_a", 32'(cnt_a), 32'(m_ca));
            chk("cnt_b", 32'(cnt_b), 32'(m_cb));
`endif
            if (rst) begin
                hold  = '0;
                hold6 = '0;
            end
        end
    end

    task automatic step(input logic r, input logic av, input logic bv, input logic ordy,
                        input logic [W-1:0] ad, input logic [W-1:0] bd);
        @(negedge CLK);
        rst = r;
        a_v = av;
        b_v = bv;
        o_r = ordy;
        a_d = ad;
        b_d = bd;
    endtask

    initial begin
        rst = 1'b1; a_v = 1'b1; b_v = 1'b1; a_d = 4'hF; b_d = 4'hA; o_r = 1'b1;
        // reset with both sources asserting
        repeat (2) step(1, 1, 1, 1, 4'hF, 4'hA);
        step(0, 1, 1, 1, 4'hF, 4'hA);
        // round-robin alternation
        repeat (20) step(0, 1, 1, 1, 4'h3, 4'hC);
        // single source B
        repeat (8) step(0, 0, 1, 1, 4'h0, 4'h5);
        // backpressure with A word held
        repeat (3) step(0, 0, 0, 1, 4'h0, 4'h0);
        step(0, 1, 0, 0, 4'h9, 4'h0);
        repeat (3) step(0, 1, 1, 0, 4'h9, 4'h6);
        step(0, 1, 1, 1, 4'h9, 4'h6);
        repeat (3) step(0, 0, 0, 1, 4'h0, 4'h0);
        // single word then drain to empty (A=0 gives the raw width pattern on dut6)
        step(0, 1, 0, 1, 4'h0, 4'h0);
        repeat (4) step(0, 0, 0, 1, 4'h0, 4'h0);
        // counter saturation and mid-run reset
        repeat (2) step(1, 0, 0, 1, 4'h0, 4'h0);
        repeat (300) step(0, 1, 0, 1, W'($urandom), 4'h0);
        repeat (2) step(0, 0, 1, 1, 4'h0, 4'h1);
        repeat (2) step(0, 0, 0, 1, 4'h0, 4'h0);
        step(1, 1, 1, 1, 4'h2, 4'h4);
        repeat (2) step(0, 0, 0, 1, 4'h0, 4'h0);
        // random traffic; idle data is random to show it never leaks
        repeat (500) step(($urandom % 50) == 0, 1'($urandom), 1'($urandom),
                          ($urandom % 4) != 0, W'($urandom), W'($urandom));
        repeat (6) step(0, 0, 0, 1, W'($urandom), W'($urandom));
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
